register_file: RTL and testbench



---
 rtl/register_file.sv | 72 +++++++
 tb/tb_register_file.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: general-purpose register file for the CPU datapath.
// 2**ADDR_WIDTH registers of DATA_WIDTH bits each, two independent
// combinational read ports, one synchronous write port. R0 is an ordinary
// register (not hardwired to zero). There is no write-through bypass.
//
// Ports:
//   clk              rising-edge clock for all state
//   rst              synchronous active-high reset; clears every register
//                    and takes priority over a simultaneous write
//   reg_write_en     write strobe, sampled at the rising edge
//   reg_write_dest   destination register index
//   reg_write_data   data to write
//   reg_read_addr_1  read port 1 index
//   reg_read_data_1  R[reg_read_addr_1], combinational
//   reg_read_addr_2  read port 2 index
//   reg_read_data_2  R[reg_read_addr_2], combinational

// One storage entry. Reset beats write so a write in the reset cycle is lost.
module register_file_entry #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (wr) q <= data;
  end
endmodule

module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write_en,
  input  logic [ADDR_WIDTH-1:0] reg_write_dest,
  input  logic [DATA_WIDTH-1:0] reg_write_data,
  input  logic [ADDR_WIDTH-1:0] reg_read_addr_1,
  output logic [DATA_WIDTH-1:0] reg_read_data_1,
  input  logic [ADDR_WIDTH-1:0] reg_read_addr_2,
  output logic [DATA_WIDTH-1:0] reg_read_data_2
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
  logic [DEPTH-1:0]                 wr_sel;

  // Decoded one-hot write select; all-zero when the strobe is low.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_entry
      assign wr_sel[g] = reg_write_en && (reg_write_dest == ADDR_WIDTH'(g));
      register_file_entry #(.DATA_WIDTH(DATA_WIDTH)) u_entry (
        .clk  (clk),
        .rst  (rst),
        .wr   (wr_sel[g]),
        .data (reg_write_data),
        .q    (regs[g])
      );
    end
  endgenerate

  // Reads come straight off the stored array: the old value is returned
  // during a write cycle and the new one only after the capturing edge.
  assign reg_read_data_1 = regs[reg_read_addr_1];
  assign reg_read_data_2 = regs[reg_read_addr_2];
endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_en;
  logic [3:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [3:0]  reg_read_addr_1;
  logic [15:0] reg_read_data_1;
  logic [3:0]  reg_read_addr_2;
  logic [15:0] reg_read_data_2;

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .reg_write_en    (reg_write_en),
    .reg_write_dest  (reg_write_dest),
    .reg_write_data  (reg_write_data),
    .reg_read_addr_1 (reg_read_addr_1),
    .reg_read_data_1 (reg_read_data_1),
    .reg_read_addr_2 (reg_read_addr_2),
    .reg_read_data_2 (reg_read_data_2)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mdl[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  // Set both read addresses, let the combinational path settle, check both.
  task automatic read_check(input string tag, input logic [3:0] a1, input logic [3:0] a2);
    reg_read_addr_1 = a1;
    reg_read_addr_2 = a2;
    exp_q.push_back(mdl[a1]);
    exp_q.push_back(mdl[a2]);
    #1;
    compare({tag, "_p1"}, reg_read_data_1);
    compare({tag, "_p2"}, reg_read_data_2);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    reg_write_en   = 1'b1;
    reg_write_dest = a;
    reg_write_data = d;
    tick();
    mdl[a] = d;
    reg_write_en = 1'b0;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) read_check(tag, 4'(i), 4'(15 - i));
  endtask

  initial begin
    rst = 1'b1; reg_write_en = 1'b0; reg_write_dest = '0; reg_write_data = '0;
    reg_read_addr_1 = '0; reg_read_addr_2 = '0;

    // Reset sweep: one edge with rst high clears everything.
    #2;
    tick();
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    rst = 1'b0;
    sweep("reset");

    // Write all registers on successive edges, then read back crosswise.
    for (int i = 0; i < 16; i++) do_write(4'(i), 16'hA000 + 16'(i));
    sweep("wr_all");

    // No bypass: old value before the edge, new value after.
    do_write(4'd3, 16'h1111);
    reg_write_en = 1'b1; reg_write_dest = 4'd3; reg_write_data = 16'h2222;
    reg_read_addr_1 = 4'd3;
    exp_q.push_back(16'h1111);
    #1 compare("bypass_pre", reg_read_data_1);
    tick();
    mdl[3] = 16'h2222;
    reg_write_en = 1'b0;
    exp_q.push_back(16'h2222);
    compare("bypass_post", reg_read_data_1);

    // Write-enable gating: strobe low, dest/data active, several edges.
    reg_write_en = 1'b0; reg_write_dest = 4'd5; reg_write_data = 16'hFFFF;
    repeat (3) tick();
    sweep("gate");

    // Back-to-back writes to one register: last write wins.
    reg_write_en = 1'b1; reg_write_dest = 4'd2; reg_write_data = 16'h1234;
    reg_read_addr_1 = 4'd2;
    tick(); mdl[2] = 16'h1234;
    exp_q.push_back(16'h1234);
    compare("b2b_first", reg_read_data_1);
    reg_write_data = 16'h4321;
    tick(); mdl[2] = 16'h4321;
    reg_write_en = 1'b0;
    exp_q.push_back(16'h4321);
    compare("b2b_second", reg_read_data_1);

    // Reset vs write: raising rst between edges changes nothing yet.
    rst = 1'b1; reg_write_en = 1'b1; reg_write_dest = 4'd7; reg_write_data = 16'hBEEF;
    read_check("rst_pending", 4'd7, 4'd3);
    tick();
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
    reg_write_en = 1'b0;
    read_check("rst_vs_wr", 4'd7, 4'd7);
    rst = 1'b0;
    sweep("rst2");

    // First write after reset release, then dual-port same address.
    do_write(4'd9, 16'h5A5A);
    read_check("dual_same", 4'd9, 4'd9);
    read_check("dual_other", 4'd9, 4'd0);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
